// File: rtl/cmd_frontend_if.sv
`default_nettype none
// ============================================================================
// Module   : cmd_frontend_if
// Purpose  : Byte-stream handshake between an upstream command source and
//            the cmd_frontend FIFO.
// Signals  : in_data  [7:0] command byte from the source
//            in_valid       in_data is valid this cycle
//            in_ready       frontend accepts a byte this cycle
// Modports : master = upstream source, slave = cmd_frontend
// Revision : 1.0 - initial release
// ============================================================================
interface cmd_frontend_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/cmd_frontend.sv
`default_nettype none
// ============================================================================
// Module   : cmd_frontend
// Purpose  : Command byte FIFO feeding a register-file core. Single-byte
//            commands issue one per cycle; a MOV opcode is issued together
//            with its immediate on two back-to-back cmd_valid cycles.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            ena        global enable, 0 freezes all state
//            flush      synchronous FIFO clear
//            hold       downstream stall, blocks issuing new commands
//            up         byte-stream slave (in_data / in_valid / in_ready)
//            cmd_out    registered command byte
//            cmd_valid  registered, cmd_out carries a real command byte
//            level      FIFO occupancy 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module cmd_frontend #(
  parameter int         DEPTH     = 8,
  parameter logic [3:0] OP_MOV    = 4'd1,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          flush,
  input  logic          hold,
  cmd_frontend_if.slave up,
  output logic [7:0]    cmd_out,
  output logic          cmd_valid,
  output logic [4:0]    level
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  typedef enum logic [0:0] {
    ISSUE = 1'b0,
    IMM   = 1'b1
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_nx;
  logic [7:0]    head_byte;
  logic [7:0]    next_byte;
  logic [7:0]    imm_hold;
  state_t        state;

  logic          push;
  logic          issue_ok;
  logic          head_is_mov;
  logic          pop1;
  logic          pop2;
  logic [1:0]    pop_cnt;

  // Pointers wrap naturally because DEPTH is a power of two; level alone
  // decides full/empty, so storage contents never need a reset.
  assign rd_ptr_nx   = rd_ptr + AW'(1);
  assign head_byte   = mem[rd_ptr];
  assign next_byte   = mem[rd_ptr_nx];

  assign up.in_ready = ena && !flush && (level < DEPTH_L);
  assign push        = up.in_valid && up.in_ready;

  // Pops only ever happen from ISSUE; IMM just replays the held immediate.
  assign issue_ok    = ena && !flush && !hold && (state == ISSUE);
  assign head_is_mov = (head_byte[3:0] == OP_MOV);
  assign pop1        = issue_ok && (level != 5'd0) && !head_is_mov;
  // A MOV waits until its immediate is queued so the pair leaves together.
  assign pop2        = issue_ok && head_is_mov && (level >= 5'd2);

  always_comb begin
    pop_cnt = 2'd0;
    if (pop1) begin
      pop_cnt = 2'd1;
    end else if (pop2) begin
      pop_cnt = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= up.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= 5'd0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (ena) begin
      if (flush) begin
        level  <= 5'd0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        rd_ptr <= rd_ptr + AW'(pop_cnt);
        level  <= level + {4'd0, push} - {3'd0, pop_cnt};
      end
    end
  end

  // Issue FSM. IMM ignores hold and flush so a MOV is never split from its
  // immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ISSUE;
      cmd_out   <= IDLE_BYTE;
      cmd_valid <= 1'b0;
      imm_hold  <= 8'h00;
    end else if (ena) begin
      case (state)
        IMM: begin
          cmd_out   <= imm_hold;
          cmd_valid <= 1'b1;
          state     <= ISSUE;
        end
        default: begin
          if (pop2) begin
            cmd_out   <= head_byte;
            cmd_valid <= 1'b1;
            imm_hold  <= next_byte;
            state     <= IMM;
          end else if (pop1) begin
            cmd_out   <= head_byte;
            cmd_valid <= 1'b1;
          end else begin
            cmd_out   <= IDLE_BYTE;
            cmd_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_frontend
// Purpose  : Self-checking bench for cmd_frontend: a directed vector table,
//            hand-written corner sequences and randomized traffic compared
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_frontend;

  localparam int         DEPTH     = 8;
  localparam logic [3:0] OP_MOV    = 4'd1;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       flush;
  logic       hold;
  logic [7:0] cmd_out;
  logic       cmd_valid;
  logic [4:0] level;

  cmd_frontend_if bus ();

  cmd_frontend #(
    .DEPTH     (DEPTH),
    .OP_MOV    (OP_MOV),
    .IDLE_BYTE (IDLE_BYTE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .flush     (flush),
    .hold      (hold),
    .up        (bus),
    .cmd_out   (cmd_out),
    .cmd_valid (cmd_valid),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of bytes plus a pending-immediate slot.
  logic [7:0] q[$];
  logic [7:0] m_out;
  logic       m_valid;
  logic       m_pend;
  logic [7:0] m_imm;
  logic       last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic head_mov();
    logic [7:0] h;
    h = q[0];
    return (h[3:0] == OP_MOV);
  endfunction

  task automatic model_reset();
    q.delete();
    m_out   = IDLE_BYTE;
    m_valid = 1'b0;
    m_pend  = 1'b0;
    m_imm   = 8'h00;
  endtask

  task automatic model_edge(input logic en, input logic v, input logic [7:0] d,
                            input logic fl, input logic ho);
    logic rdy;
    if (en) begin
      rdy = !fl && (q.size() < DEPTH);
      if (m_pend) begin
        m_out   = m_imm;
        m_valid = 1'b1;
        m_pend  = 1'b0;
      end else if (!fl && !ho && q.size() >= 1 && !head_mov()) begin
        m_out   = q.pop_front();
        m_valid = 1'b1;
      end else if (!fl && !ho && q.size() >= 2 && head_mov()) begin
        m_out   = q.pop_front();
        m_imm   = q.pop_front();
        m_pend  = 1'b1;
        m_valid = 1'b1;
      end else begin
        m_out   = IDLE_BYTE;
        m_valid = 1'b0;
      end
      if (fl) q.delete();
      if (v && rdy) q.push_back(d);
    end
  endtask

  // Called just after a falling edge: drive, check in_ready, clock, check.
  task automatic step(input logic en, input logic v, input logic [7:0] d,
                      input logic fl, input logic ho);
    logic exp_rdy;
    ena = en; bus.in_valid = v; bus.in_data = d; flush = fl; hold = ho;
    #1;
    exp_rdy    = en && !fl && (q.size() < DEPTH);
    last_ready = bus.in_ready;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    model_edge(en, v, d, fl, ho);
    @(negedge clk);
    chk("cmd_out", {24'd0, cmd_out}, {24'd0, m_out});
    chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_valid});
    chk("level", {27'd0, level}, q.size());
  endtask

  task automatic do_reset();
    ena = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; flush = 1'b0; hold = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rst_cmd_out", {24'd0, cmd_out}, {24'd0, IDLE_BYTE});
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ho;
    logic       rdy;
    logic [7:0] out;
    logic       val;
    logic [4:0] lvl;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Single byte latency, then a MOV opcode (8'h51) waiting for its immediate.
    tbl[0]  = '{1'b1, 8'h32, 1'b0, 1'b1, 8'h00, 1'b0, 5'd1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h32, 1'b1, 5'd0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0};
    tbl[3]  = '{1'b1, 8'h51, 1'b0, 1'b1, 8'h00, 1'b0, 5'd1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 5'd1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 5'd1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 5'd1};
    tbl[7]  = '{1'b1, 8'hA7, 1'b0, 1'b1, 8'h00, 1'b0, 5'd2};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h51, 1'b1, 5'd0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA7, 1'b1, 5'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0};

    model_reset();
    last_ready = 1'b0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      step(1'b1, tbl[i].v, tbl[i].d, 1'b0, tbl[i].ho);
      chk($sformatf("tbl%0d_ready", i), {31'd0, last_ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_out", i), {24'd0, cmd_out}, {24'd0, tbl[i].out});
      chk($sformatf("tbl%0d_valid", i), {31'd0, cmd_valid}, {31'd0, tbl[i].val});
      chk($sformatf("tbl%0d_level", i), {27'd0, level}, {27'd0, tbl[i].lvl});
    end

    // Fill to DEPTH under hold, then release with in_valid still high.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 8'(8'h10 * (i + 1)), 1'b0, 1'b1);
    chk("full_level", {27'd0, level}, DEPTH);
    step(1'b1, 1'b1, 8'hE0, 1'b0, 1'b1);
    chk("full_ready", {31'd0, last_ready}, 32'd0);
    chk("full_level_hold", {27'd0, level}, DEPTH);
    step(1'b1, 1'b1, 8'hE0, 1'b0, 1'b0);
    chk("full_first_out", {24'd0, cmd_out}, 32'h10);
    chk("full_release_level", {27'd0, level}, DEPTH - 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 8'(8'hC0 + 8'(i * 16)), 1'b0, 1'b0);
      chk("steady_level", {27'd0, level}, DEPTH - 1);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("drained_level", {27'd0, level}, 32'd0);

    // Flush while the immediate of a MOV is pending.
    do_reset();
    step(1'b1, 1'b1, 8'h31, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'hA7, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h42, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_opcode", {24'd0, cmd_out}, 32'h31);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_imm", {24'd0, cmd_out}, 32'hA7);
    chk("flush_imm_valid", {31'd0, cmd_valid}, 32'd1);
    chk("flush_level", {27'd0, level}, 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_idle", {31'd0, cmd_valid}, 32'd0);

    // Asynchronous reset while in IMM.
    do_reset();
    step(1'b1, 1'b1, 8'h31, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'hA7, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("imm_opcode", {24'd0, cmd_out}, 32'h31);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("async_rst_out", {24'd0, cmd_out}, {24'd0, IDLE_BYTE});
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("no_stale_imm", {31'd0, cmd_valid}, 32'd0);
    end

    // ena=0 freezes everything and blocks push.
    do_reset();
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h66, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
      chk("frz_ready", {31'd0, last_ready}, 32'd0);
      chk("frz_out", {24'd0, cmd_out}, 32'h55);
      chk("frz_valid", {31'd0, cmd_valid}, 32'd1);
      chk("frz_level", {27'd0, level}, 32'd1);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("thaw_out", {24'd0, cmd_out}, 32'h66);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 9) < 3) d[3:0] = OP_MOV;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, d,
           $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
